fifo_stream_reader: RTL and testbench

//  Read-side consumer for the async FIFO, entirely in the read (slow) clock domain.
//  - Pops words from the FIFO read port, absorbing the FIFO's registered 1-cycle dout latency.
//  - Presents the words downstream as a valid/ready stream.
//  - Sustains 1 word/cycle under full backpressure-free flow, with word order preserved.

---
 rtl/fifo_rdr_pkg.sv | 21 ++
 rtl/fifo_rdr_skid.sv | 68 ++++++
 rtl/fifo_stream_reader.sv | 75 +++++++
 tb/tb_fifo_stream_reader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rdr_pkg.sv
// Shared types and helpers for the FIFO read-side stream consumer.
// Optional accepted-word counter is enabled with FIFO_RDR_STATS_EN.
package fifo_rdr_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    localparam int BUF_DEPTH = 2;

    function automatic occ_t occ_inc(input occ_t o);
        return (o == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
    endfunction

    function automatic occ_t occ_dec(input occ_t o);
        return (o == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
    endfunction

endpackage

// File: rtl/fifo_rdr_skid.sv
// Two-entry in-order buffer; head is the oldest word, tail the one behind it.
// Flush empties the buffer and overrides any push or pop in the same cycle.
module fifo_rdr_skid
    import fifo_rdr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic [WIDTH-1:0] head
);

    occ_t             occ_next;
    logic [WIDTH-1:0] tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= OCC_EMPTY;
        end else begin
            occ <= occ_next;
        end
    end

    always_comb begin
        occ_next = occ;
        if (flush) begin
            occ_next = OCC_EMPTY;
        end else if (push && !pop) begin
            occ_next = occ_inc(occ);
        end else if (pop && !push) begin
            occ_next = occ_dec(occ);
        end
    end

    // Simultaneous push and pop keeps the count; the new word lands behind what remains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else if (!flush) begin
            case ({push, pop})
                2'b10: begin
                    if (occ == OCC_EMPTY) head <= push_data;
                    else                  tail <= push_data;
                end
                2'b01: head <= tail;
                2'b11: begin
                    if (occ == OCC_FULL) begin
                        head <= tail;
                        tail <= push_data;
                    end else begin
                        head <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && occ == OCC_FULL));

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the async FIFO read port and re-presents words as a valid/ready stream.
// Define FIFO_RDR_STATS_EN to add the saturating accepted-word counter rd_count.
module fifo_stream_reader
    import fifo_rdr_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef FIFO_RDR_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
`ifdef FIFO_RDR_STATS_EN
    , output logic [CNT_W-1:0] rd_count
`endif
);

    // Stream handshake: a word transfers on every rd_clk edge where m_valid && m_ready;
    // once m_valid is high, m_valid and m_data hold until that transfer happens.
    occ_t       occ;
    logic       inflight;
    logic       pop;
    logic [2:0] credit;

    assign m_valid = (occ != OCC_EMPTY);
    assign pop     = m_valid & m_ready;

    // Credit counts buffered plus in-flight words after this cycle's pop, so a pop
    // frees a slot immediately and the stream keeps one word per cycle.
    always_comb begin
        credit     = 3'(occ) + 3'(inflight) - 3'(pop);
        fifo_rd_en = !rst && !flush && !fifo_empty && (credit < 3'(BUF_DEPTH));
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else if (flush) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    fifo_rdr_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (rd_clk),
        .rst      (rst),
        .flush    (flush),
        .push     (inflight),
        .push_data(fifo_dout),
        .pop      (pop),
        .occ      (occ),
        .head     (m_data)
    );

`ifdef FIFO_RDR_STATS_EN
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
        end else if (pop && (rd_count != '1)) begin
            rd_count <= rd_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small behavioural FIFO read port.
// Build with FIFO_RDR_STATS_EN defined to also exercise the saturating rd_count.
module tb_fifo_stream_reader;
    import fifo_rdr_pkg::*;

    logic       rd_clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en;
    logic       flush = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
`ifdef FIFO_RDR_STATS_EN
    logic [3:0] rd_count;
`endif

    int checks = 0;
    int errors = 0;

    // FIFO model: tasks append to load_q; the model owns fifo_q and its outputs.
    logic [7:0] load_q[$];
    logic [7:0] fifo_q[$];
    int         load_rd = 0;
    logic       clr_req = 1'b0;

    // Monitor state, read by tests relative to a snapshot taken at test start.
    logic [7:0] got_q[$];
    int         rd_en_cnt = 0;

    always #5 rd_clk = ~rd_clk;

    fifo_stream_reader #(
        .WIDTH(8)
`ifdef FIFO_RDR_STATS_EN
        , .CNT_W(4)
`endif
    ) dut (
        .rd_clk    (rd_clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready)
`ifdef FIFO_RDR_STATS_EN
        , .rd_count(rd_count)
`endif
    );

    always @(posedge rd_clk) begin
        if (clr_req) begin
            fifo_q.delete();
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= fifo_q.pop_front();
        end
        while (load_rd < load_q.size()) begin
            fifo_q.push_back(load_q[load_rd]);
            load_rd++;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge rd_clk) begin
        if (!rst && m_valid && m_ready) got_q.push_back(m_data);
        if (fifo_rd_en) rd_en_cnt++;
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic fifo_load(input logic [7:0] w);
        load_q.push_back(w);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++;
        if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
        checks++;
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [5:0] exp_en;
        logic [5:0] exp_vld;
        logic [7:0] exp_d[6];
        exp_en  = 6'b000111;
        exp_vld = 6'b011100;
        exp_d   = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        tick();
        m_ready = 1'b1;
        fifo_load(8'h11); fifo_load(8'h22); fifo_load(8'h33);
        tick();
        for (int c = 0; c < 6; c++) begin
            @(negedge rd_clk);
            checks++;
            if (fifo_rd_en !== exp_en[c]) begin
                errors++; $display("FAIL stream_rd_en c%0d: got %b expected %b", c, fifo_rd_en, exp_en[c]);
            end
            checks++;
            if (m_valid !== exp_vld[c]) begin
                errors++; $display("FAIL stream_m_valid c%0d: got %b expected %b", c, m_valid, exp_vld[c]);
            end
            if (exp_vld[c]) begin
                checks++;
                if (m_data !== exp_d[c]) begin
                    errors++; $display("FAIL stream_m_data c%0d: got %h expected %h", c, m_data, exp_d[c]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int         en_base;
        int         got_base;
        logic [7:0] exp_w[4];
        exp_w = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_load(exp_w[i]);
        en_base = rd_en_cnt;
        tick();
        for (int c = 0; c < 12; c++) begin
            @(negedge rd_clk);
            if (c >= 2) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 8'hA1) begin
                    errors++; $display("FAIL hold c%0d: got valid %b data %h expected valid 1 data a1", c, m_valid, m_data);
                end
            end
        end
        checks++;
        if (rd_en_cnt - en_base != 2) begin
            errors++; $display("FAIL hold_rd_en_pulses: got %0d expected 2", rd_en_cnt - en_base);
        end
        checks++;
        if (dut.occ !== OCC_FULL) begin
            errors++; $display("FAIL hold_occ: got %0d expected 2", dut.occ);
        end
        got_base = got_q.size();
        tick();
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge rd_clk);
            checks++;
            if (m_valid !== (c < 4)) begin
                errors++; $display("FAIL drain_valid c%0d: got %b expected %b", c, m_valid, (c < 4));
            end
        end
        checks++;
        if (got_q.size() - got_base != 4) begin
            errors++; $display("FAIL drain_count: got %0d expected 4", got_q.size() - got_base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[got_base + i] !== exp_w[i]) begin
                    errors++; $display("FAIL drain_word %0d: got %h expected %h", i, got_q[got_base + i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_alternate_ready();
        int got_base;
        int credit;
        got_base = got_q.size();
        tick();
        for (int i = 1; i <= 8; i++) fifo_load(8'(i));
        tick();
        for (int c = 0; c < 40; c++) begin
            m_ready = (c % 2 == 0);
            @(negedge rd_clk);
            if (fifo_rd_en) begin
                credit = int'(dut.occ) + int'(dut.inflight) - int'(m_valid && m_ready);
                checks++;
                if (credit >= 2) begin
                    errors++; $display("FAIL alt_credit c%0d: got %0d expected < 2", c, credit);
                end
            end
            tick();
        end
        m_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (got_q.size() - got_base != 8) begin
            errors++; $display("FAIL alt_count: got %0d expected 8", got_q.size() - got_base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[got_base + i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL alt_word %0d: got %h expected %h", i, got_q[got_base + i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_flush();
        int got_base;
        got_base = got_q.size();
        tick();
        m_ready = 1'b0;
        fifo_load(8'hB1);
        tick();
        repeat (3) @(negedge rd_clk);
        tick();
        fifo_load(8'hB2); fifo_load(8'hB3);
        tick();
        @(negedge rd_clk);
        checks++;
        if (fifo_rd_en !== 1'b1 || dut.occ !== OCC_ONE) begin
            errors++; $display("FAIL flush_setup: got rd_en %b occ %0d expected rd_en 1 occ 1", fifo_rd_en, dut.occ);
        end
        tick();
        flush = 1'b1;
        @(negedge rd_clk);
        checks++;
        if (fifo_rd_en !== 1'b0 || dut.inflight !== 1'b1) begin
            errors++; $display("FAIL flush_cycle: got rd_en %b inflight %b expected rd_en 0 inflight 1", fifo_rd_en, dut.inflight);
        end
        tick();
        flush = 1'b0;
        m_ready = 1'b1;
        @(negedge rd_clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL flush_m_valid: got %b expected 0", m_valid);
        end
        repeat (6) @(negedge rd_clk);
        checks++;
        if (got_q.size() - got_base != 1) begin
            errors++; $display("FAIL flush_count: got %0d expected 1", got_q.size() - got_base);
        end else begin
            checks++;
            if (got_q[got_base] !== 8'hB3) begin
                errors++; $display("FAIL flush_next_word: got %h expected b3", got_q[got_base]);
            end
        end
    endtask

    task automatic test_async_reset();
        tick();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) fifo_load(8'hD1 + 8'(i));
        tick();
        repeat (3) @(negedge rd_clk);
        checks++;
        if (m_valid !== 1'b1 || fifo_rd_en !== 1'b1) begin
            errors++; $display("FAIL arst_setup: got valid %b rd_en %b expected 1 1", m_valid, fifo_rd_en);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL arst_outputs: got valid %b data %h rd_en %b expected 0 00 0", m_valid, m_data, fifo_rd_en);
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge rd_clk);
            checks++;
            if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
                errors++; $display("FAIL arst_idle c%0d: got rd_en %b valid %b expected 0 0", c, fifo_rd_en, m_valid);
            end
        end
    endtask

`ifdef FIFO_RDR_STATS_EN
    task automatic test_stats();
        tick();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) fifo_load(8'h40 + 8'(i));
        tick();
        repeat (40) @(negedge rd_clk);
        checks++;
        if (rd_count !== 4'hF) begin
            errors++; $display("FAIL stats_saturate: got %h expected f", rd_count);
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge rd_clk);
        checks++;
        if (rd_count !== 4'hF) begin
            errors++; $display("FAIL stats_flush: got %h expected f", rd_count);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rd_count !== 4'h0) begin
            errors++; $display("FAIL stats_reset: got %h expected 0", rd_count);
        end
        tick();
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_alternate_ready();
        test_flush();
        test_async_reset();
`ifdef FIFO_RDR_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
